// File: rtl/booth_r4_mul_seq_if.sv
// Operand/product handshake bundle for the iterative radix-4 Booth multiplier.
// The master is the operand issuer plus result consumer; the slave is the multiplier.
interface booth_r4_mul_seq_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out;
    logic                 busy;

    modport master (
        output in_valid, x, y, is_signed, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, x, y, is_signed, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

// File: rtl/booth_r4_mul_seq.sv
// Iterative radix-4 Booth multiplier: one digit per clock, signed or unsigned per
// operation, fixed latency of WIDTH/2+2 cycles from accept to out_valid.
module booth_r4_mul_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH/2+2)
) (
    input  logic               clk,
    input  logic               reset,
    booth_r4_mul_seq_if.slave  bus
);
    localparam int ACC_W = 2*WIDTH + 4;
    localparam int YE_W  = WIDTH + 3;
    localparam logic [CNT_W-1:0] NDIG = CNT_W'(WIDTH/2 + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("booth_r4_mul_seq: WIDTH must be even and >= 4");
    end

    logic [1:0]               state;
    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  xsh;
    logic signed [ACC_W-1:0]  acc;
    logic [YE_W-1:0]          ysh;
    logic [2*WIDTH-1:0]       prod;
    logic                     ext_x;
    logic                     ext_y;

    // Partial product for one Booth triplet; xs already carries the digit weight.
    function automatic logic signed [ACC_W-1:0] booth_pp(
        input logic [2:0]               trip,
        input logic signed [ACC_W-1:0]  xs
    );
        case (trip)
            3'b001, 3'b010: return xs;
            3'b011:         return xs <<< 1;
            3'b100:         return -(xs <<< 1);
            3'b101, 3'b110: return -xs;
            default:        return '0;
        endcase
    endfunction

    assign ext_x = bus.is_signed & bus.x[WIDTH-1];
    assign ext_y = bus.is_signed & bus.y[WIDTH-1];

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state == S_BUSY);
    assign bus.out       = prod;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            xsh   <= '0;
            ysh   <= '0;
            acc   <= '0;
            prod  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        xsh   <= {{(ACC_W-WIDTH){ext_x}}, bus.x};
                        ysh   <= {ext_y, ext_y, bus.y, 1'b0};
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Multiplicand walks left two bits per digit instead of a barrel shift.
                    if (cnt == NDIG) begin
                        prod  <= acc[2*WIDTH-1:0];
                        state <= S_DONE;
                    end else begin
                        acc <= acc + booth_pp(ysh[2:0], xsh);
                        xsh <= xsh <<< 2;
                        ysh <= ysh >> 2;
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_r4_mul_seq.sv
// Directed WIDTH=16 checks plus randomized WIDTH=8 operations against an
// arithmetic reference product, with random result-side stalls.
module tb_booth_r4_mul_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    booth_r4_mul_seq_if #(.WIDTH(16)) b16();
    booth_r4_mul_seq_if #(.WIDTH(8))  b8();

    booth_r4_mul_seq #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .bus(b16.slave));
    booth_r4_mul_seq #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(b8.slave));

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    // Reference: interpret operands as plain integers, multiply, keep 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] xv,
                                            input logic [31:0] yv, input logic s);
        longint xa, ya, p;
        logic [63:0] mask;
        xa = longint'({32'b0, xv});
        ya = longint'({32'b0, yv});
        if (s && xv[w-1]) xa = xa - (longint'(1) << w);
        if (s && yv[w-1]) ya = ya - (longint'(1) << w);
        p = xa * ya;
        mask = (64'd1 << (2*w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    task automatic op16(input logic [15:0] xv, input logic [15:0] yv, input logic s,
                        input logic [31:0] exp, input string tag);
        int cyc;
        chk({tag, "_in_ready"}, 64'(b16.in_ready), 64'd1);
        b16.x = xv; b16.y = yv; b16.is_signed = s; b16.in_valid = 1'b1;
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        b16.x = 16'($urandom); b16.y = 16'($urandom); b16.is_signed = 1'($urandom);
        chk({tag, "_busy"}, {62'd0, b16.busy, b16.in_ready}, 64'b10);
        cyc = 0;
        while (!b16.out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd10);
        chk({tag, "_out"}, 64'(b16.out), 64'(exp));
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        b16.out_ready = 1'b0;
        chk({tag, "_release"}, {62'd0, b16.out_valid, b16.in_ready}, 64'b01);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        logic [31:0] bp_exp;
        logic        seen;
        int          cyc;
        logic [7:0]  xv, yv;
        logic        s;
        logic [15:0] exp8;

        b16.in_valid = 0; b16.x = 0; b16.y = 0; b16.is_signed = 0; b16.out_ready = 0;
        b8.in_valid = 0;  b8.x = 0;  b8.y = 0;  b8.is_signed = 0;  b8.out_ready = 0;

        #2 reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_state16", {61'd0, b16.in_ready, b16.out_valid, b16.busy}, 64'b100);
        chk("rst_out16", 64'(b16.out), 64'd0);
        chk("rst_state8", {61'd0, b8.in_ready, b8.out_valid, b8.busy}, 64'b100);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        op16(16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, "neg3x7");
        op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "ffff_u");
        op16(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "ffff_s");
        op16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "min_min");
        op16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "min_max");
        op16(16'h0000, 16'h1234, 1'b1, 32'h00000000, "zero");

        // Backpressure: result must hold for 20 cycles while a new request is offered.
        bp_exp = 32'(ref_mul(16, 32'h1234, 32'h00AB, 1'b0));
        b16.x = 16'h1234; b16.y = 16'h00AB; b16.is_signed = 1'b0; b16.in_valid = 1'b1;
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        cyc = 0;
        while (!b16.out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_latency", 64'(cyc), 64'd10);
        b16.x = 16'h0003; b16.y = 16'h0003; b16.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("bp_hold", {30'd0, b16.out_valid, b16.in_ready, b16.out}, {30'd0, 2'b10, bp_exp});
            @(posedge clk); #1;
        end
        b16.in_valid = 1'b0;
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        b16.out_ready = 1'b0;
        chk("bp_release", {62'd0, b16.out_valid, b16.in_ready}, 64'b01);
        op16(16'h0011, 16'h0022, 1'b0, 32'h00000242, "after_bp");

        // Asynchronous reset in the 4th busy cycle discards the operation.
        b16.x = 16'hABCD; b16.y = 16'h1357; b16.is_signed = 1'b1; b16.in_valid = 1'b1;
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_busy", 64'(b16.busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("async_rst", {28'd0, b16.out_valid, b16.in_ready, b16.busy, 1'b0, b16.out},
            {28'd0, 4'b0100, 32'd0});
        #2 reset = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            seen = seen | b16.out_valid;
        end
        chk("no_ghost_valid", 64'(seen), 64'd0);
        op16(16'd5, 16'd6, 1'b0, 32'd30, "rst_next");

        // Randomized WIDTH=8 operations, with ignored input noise while busy.
        for (int i = 0; i < 2000; i++) begin
            xv = 8'($urandom); yv = 8'($urandom); s = 1'($urandom);
            exp8 = 16'(ref_mul(8, {24'd0, xv}, {24'd0, yv}, s));
            b8.x = xv; b8.y = yv; b8.is_signed = s; b8.in_valid = 1'b1;
            @(posedge clk); #1;
            cyc = 0;
            while (!b8.out_valid && cyc < 30) begin
                b8.in_valid = 1'($urandom);
                b8.x = 8'($urandom); b8.y = 8'($urandom); b8.is_signed = 1'($urandom);
                @(posedge clk); #1;
                cyc++;
            end
            b8.in_valid = 1'b0;
            chk("r8_latency", 64'(cyc), 64'd6);
            chk("r8_product", 64'(b8.out), 64'(exp8));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            chk("r8_hold", {47'd0, b8.out_valid, b8.out}, {47'd0, 1'b1, exp8});
            b8.out_ready = 1'b1;
            @(posedge clk); #1;
            b8.out_ready = 1'b0;
            chk("r8_single", {62'd0, b8.out_valid, b8.in_ready}, 64'b01);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/booth_r4_mul_seq.md
Name: booth_r4_mul_seq

Overview:
Parametrised iterative radix-4 Booth multiplier. It is the successor to the team's fixed 16-bit Booth multiplier and adds generic operand width, per-operation signed/unsigned mode, valid/ready handshakes on input and output, and a deterministic latency. It retires one Booth digit per clock and sits between an operand-issuing controller and a result consumer that may apply backpressure.

Parameters:
WIDTH, 16, operand width in bits; must be even and >= 4 (elaboration error otherwise)
CNT_W, $clog2(WIDTH/2+2), digit counter width (derived; not overridden)

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
x  in  WIDTH  multiplicand
y  in  WIDTH  multiplier
is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
out  out  2*WIDTH  product
busy  out  1  high while in BUSY state

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, out=0, busy=0, internal registers=0. This applies at any time, including mid-operation. The in-flight operation is discarded, and no out_valid follows it.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch the operands, clear the accumulator, set cnt=0, and go to BUSY.
  - BUSY: in_ready=0, busy=1. Each cycle, process digit cnt, then cnt++. After digit D-1, where D = WIDTH/2+1, go to DONE.
  - DONE: out_valid=1, out held stable. On out_ready=1, go to IDLE with out_valid=0 on the next cycle.
  - DONE does not accept new operands in the same cycle as the handoff; in_ready is high only in IDLE.
- Operand extension (at latch):
  - yext = {ext, ext, y, 0}, where ext = is_signed ? y[WIDTH-1] : 0 (WIDTH+3 bits).
  - xext = x extended to WIDTH+2 bits, using sign or zero extension per is_signed.
- Digit k uses triplet yext[2k+2 : 2k] and adds the following into the accumulator at weight 2^(2k):
  - 000, 111 -> 0
  - 001, 010 -> +xext
  - 011 -> +2*xext
  - 100 -> -2*xext
  - 101, 110 -> -xext
- Arithmetic and widths:
  - Partial products are sign-extended to the accumulator width (2*WIDTH+4 bits).
  - out = accumulator[2*WIDTH-1:0]. The result is exact modulo 2^(2*WIDTH) for both modes.
- D is always WIDTH/2+1 digits. In signed mode the extra digit is 000 or 111 and contributes 0, so latency does not depend on mode or data.
- Latency: operands accepted at edge T, out_valid=1 from edge T+D+1.
  - For WIDTH=16 this is T+10.
  - Throughput is one result per D+2 cycles when out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out, out_valid and state hold indefinitely.
- Inputs are ignored outside IDLE: x, y, is_signed and in_valid changing in BUSY or DONE have no effect.
- Zero operands need no short-circuit; they take the full latency.
- No X may propagate: unused triplet codes do not exist, so every case is decoded.

Test Plan:
- WIDTH=16, is_signed=1, x=0xFFFD (-3), y=0x0007 -> out=0xFFFFFFEB, out_valid rises exactly 10 cycles after accept.
- WIDTH=16, is_signed=0, x=0xFFFF, y=0xFFFF -> out=0xFFFE0001; is_signed=1 with the same operands -> out=0x00000001.
- WIDTH=16, is_signed=1, x=0x8000, y=0x8000 -> out=0x40000000; x=0x8000, y=0x7FFF -> out=0xC0008000.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> out stable, in_ready=0, a new in_valid is ignored; release -> IDLE next cycle, next operation accepted.
- Reset asserted on the 4th BUSY cycle -> out_valid=0, out=0, in_ready=1 immediately (asynchronous); the next operation 5*6 (unsigned) -> out=30.
- WIDTH=8 build, random 2000 ops in both modes against a reference model with random out_ready stalls -> all products match, no lost or duplicated results.
